// File: rtl/ia_ship_placer_if.sv
// Placement bus between the IA ship placer (master) and the board memory
// (slave). The master presents a ship position, the slave acknowledges a
// successful write with ship_placed.
interface ia_ship_placer_if;
  logic [3:0] cell_x;
  logic [3:0] cell_y;
  logic       direction;
  logic [3:0] dimension;
  logic       we;
  logic [4:0] new_value;
  logic       ship_placed;

  modport master (
    output cell_x, cell_y, direction, dimension, we, new_value,
    input  ship_placed
  );

  modport slave (
    input  cell_x, cell_y, direction, dimension, we, new_value,
    output ship_placed
  );
endinterface

// File: rtl/ia_ship_placer.sv
// IA fleet placer: draws pseudo-random positions from a 16-bit LFSR,
// discards positions that leave the 10x10 board, previews and writes each
// legal position to the board memory, and retries until the memory
// acknowledges. Ends in a sticky done, or a sticky fail once one ship has
// used up its retry budget.
module ia_ship_placer #(
  parameter logic [15:0] SEED        = 16'hACE1,
  parameter int          NUM_SHIPS   = 5,
  parameter int          WAIT_CYCLES = 4,
  parameter int          MAX_RETRY   = 64
) (
  input  logic               clk_in,
  input  logic               rst_n,
  input  logic               start,
  input  logic [1:0]         play_status,
  input  logic [1:0]         turn_ia_placing,
  ia_ship_placer_if.master   bus,
  output logic               busy,
  output logic               done,
  output logic               fail
);

  // An all-zero seed would lock the LFSR, so it is replaced by 1.
  localparam logic [15:0] SEED_EFF = (SEED == 16'h0000) ? 16'h0001 : SEED;

  localparam int IW = $clog2(NUM_SHIPS + 1);
  localparam int RW = $clog2(MAX_RETRY + 1);
  localparam int WW = $clog2(WAIT_CYCLES + 1);

  localparam logic [IW-1:0] IDX_LAST   = IW'(NUM_SHIPS - 1);
  localparam logic [RW-1:0] RETRY_LAST = RW'(MAX_RETRY - 1);
  localparam logic [WW-1:0] WAIT_LAST  = WW'(WAIT_CYCLES - 1);

  typedef enum logic [3:0] {
    S_IDLE, S_GEN, S_CHECK, S_PREVIEW, S_WRITE, S_WAIT, S_NEXT, S_DONE, S_FAIL
  } state_t;

  state_t state_q, state_d;

  logic [15:0]   lfsr_q;
  logic [15:0]   lfsr_next;
  logic [3:0]    cell_x_q;
  logic [3:0]    cell_y_q;
  logic          direction_q;
  logic [3:0]    dimension_q;
  logic [IW-1:0] idx_q;
  logic [RW-1:0] retry_q;
  logic [WW-1:0] wait_cnt_q;
  logic          done_q;
  logic          fail_q;

  logic          run_ok;
  logic [4:0]    span;
  logic          fits;
  logic          timeout;

  // Ship length by fleet index: 5,4,3,3,2.
  function automatic logic [3:0] dim_of(input logic [IW-1:0] i);
    case (int'(i))
      0:       dim_of = 4'd5;
      1:       dim_of = 4'd4;
      2:       dim_of = 4'd3;
      3:       dim_of = 4'd3;
      default: dim_of = 4'd2;
    endcase
  endfunction

  assign lfsr_next = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
  assign run_ok    = (play_status == turn_ia_placing);

  // Far end of the ship along its direction, in 5 bits so 15+5 cannot wrap.
  assign span    = {1'b0, (direction_q ? cell_y_q : cell_x_q)} + {1'b0, dimension_q};
  assign fits    = (cell_x_q <= 4'd9) && (cell_y_q <= 4'd9) && (span <= 5'd10);
  assign timeout = (wait_cnt_q == WAIT_LAST);

  // Decoded from the state register so an asynchronous reset drops we at once.
  assign busy = state_q inside {S_GEN, S_CHECK, S_PREVIEW, S_WRITE, S_WAIT, S_NEXT};
  assign done = done_q;
  assign fail = fail_q;

  assign bus.cell_x    = cell_x_q;
  assign bus.cell_y    = cell_y_q;
  assign bus.direction = direction_q;
  assign bus.dimension = dimension_q;
  assign bus.we        = (state_q == S_WRITE);
  assign bus.new_value = 5'd2;

  // State register.
  always_ff @(posedge clk_in or negedge rst_n) begin
    // NOTE: non-blocking assignments so every register updates from pre-edge values.
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic; leaving the placing turn aborts any busy state.
  always_comb begin
    // NOTE: default first, so no path leaves state_d unassigned and no latch is inferred.
    state_d = state_q;
    case (state_q)
      S_IDLE:    if (start && run_ok) state_d = S_GEN;
      S_GEN:     state_d = S_CHECK;
      S_CHECK:   state_d = fits ? S_PREVIEW : S_GEN;
      S_PREVIEW: state_d = S_WRITE;
      S_WRITE:   state_d = S_WAIT;
      S_WAIT: begin
        if (bus.ship_placed)  state_d = S_NEXT;
        else if (timeout)     state_d = (retry_q == RETRY_LAST) ? S_FAIL : S_GEN;
      end
      S_NEXT:    state_d = (idx_q == IDX_LAST) ? S_DONE : S_GEN;
      S_DONE:    state_d = S_IDLE;
      S_FAIL:    state_d = S_IDLE;
      default:   state_d = S_IDLE;
    endcase
    if (busy && !run_ok) state_d = S_IDLE;
  end

  // Datapath: LFSR, ship position, fleet/retry/wait counters and sticky flags.
  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      lfsr_q      <= SEED_EFF;
      cell_x_q    <= '0;
      cell_y_q    <= '0;
      direction_q <= 1'b0;
      dimension_q <= 4'd5;
      idx_q       <= '0;
      retry_q     <= '0;
      wait_cnt_q  <= '0;
      done_q      <= 1'b0;
      fail_q      <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start && run_ok) begin
            idx_q       <= '0;
            retry_q     <= '0;
            dimension_q <= dim_of('0);
            done_q      <= 1'b0;
            fail_q      <= 1'b0;
          end
        end
        S_GEN: begin
          lfsr_q      <= lfsr_next;
          cell_x_q    <= lfsr_next[3:0];
          cell_y_q    <= lfsr_next[7:4];
          direction_q <= lfsr_next[8];
        end
        S_WRITE: wait_cnt_q <= '0;
        S_WAIT: begin
          // An acknowledge on the timeout cycle wins over the retry.
          if (!bus.ship_placed) begin
            if (timeout) retry_q    <= retry_q + 1'b1;
            else         wait_cnt_q <= wait_cnt_q + 1'b1;
          end
        end
        S_NEXT: begin
          idx_q   <= idx_q + 1'b1;
          retry_q <= '0;
          if (idx_q != IDX_LAST) dimension_q <= dim_of(idx_q + 1'b1);
        end
        default: ;
      endcase
      if (state_d == S_DONE) done_q <= 1'b1;
      if (state_d == S_FAIL) fail_q <= 1'b1;
    end
  end

endmodule

// File: tb/tb_ia_ship_placer.sv
// Self-checking bench for ia_ship_placer: a board-memory responder with a
// programmable acknowledge delay, a write monitor with an independent LFSR
// placement model, a table of fleet scenarios and directed corner sequences.
`timescale 1ns/1ps
module tb_ia_ship_placer;

  localparam logic [15:0] SEED = 16'hACE1;
  localparam logic [1:0]  TURN = 2'd2;

  logic       clk_in = 1'b0;
  logic       rst_n  = 1'b0;
  logic       start  = 1'b0;
  logic [1:0] play_status     = TURN;
  logic [1:0] turn_ia_placing = TURN;
  logic       busy, done, fail;

  ia_ship_placer_if bus();

  ia_ship_placer #(
    .SEED(SEED), .NUM_SHIPS(5), .WAIT_CYCLES(4), .MAX_RETRY(64)
  ) dut (
    .clk_in(clk_in), .rst_n(rst_n), .start(start),
    .play_status(play_status), .turn_ia_placing(turn_ia_placing),
    .bus(bus), .busy(busy), .done(done), .fail(fail)
  );

  always #5 clk_in = ~clk_in;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // ---------------- placement model and write monitor ----------------
  typedef struct {
    logic [3:0] x;
    logic [3:0] y;
    logic       dir;
    logic [3:0] dim;
  } wr_t;

  wr_t         wq[$];
  logic [15:0] model_lfsr = SEED;
  int          range_viol = 0;

  function automatic logic [15:0] lfsr_step(input logic [15:0] l);
    return {l[14:0], l[15] ^ l[13] ^ l[12] ^ l[10]};
  endfunction

  function automatic bit legal(input logic [3:0] x, input logic [3:0] y,
                               input logic dir, input logic [3:0] dim);
    int s;
    s = dir ? int'(y) : int'(x);
    return (x <= 4'd9) && (y <= 4'd9) && (s + int'(dim) <= 10);
  endfunction

  always @(negedge clk_in) begin : monitor
    wr_t w;
    int  guard;
    if (rst_n && bus.we) begin
      w.x = bus.cell_x; w.y = bus.cell_y; w.dir = bus.direction; w.dim = bus.dimension;
      wq.push_back(w);
      if (!legal(w.x, w.y, w.dir, w.dim)) range_viol++;
      guard = 0;
      do begin
        model_lfsr = lfsr_step(model_lfsr);
        guard++;
      end while (!legal(model_lfsr[3:0], model_lfsr[7:4], model_lfsr[8], w.dim) && guard < 70000);
      check("write_pos", {23'd0, w.x, w.y, w.dir},
            {23'd0, model_lfsr[3:0], model_lfsr[7:4], model_lfsr[8]});
    end
  end

  // ---------------- board-memory responder ----------------
  int ack_delay = 0;  // 0 = never acknowledge, n = ack in the n-th WAIT cycle

  initial begin
    bus.ship_placed = 1'b0;
    forever begin
      @(negedge clk_in);
      if (rst_n && bus.we && ack_delay > 0) begin
        repeat (ack_delay) @(negedge clk_in);
        bus.ship_placed = 1'b1;
        @(negedge clk_in);
        bus.ship_placed = 1'b0;
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_we(output bit ok);
    ok = 1'b0;
    for (int c = 0; c < 4000; c++) begin
      tick();
      if (bus.we) begin
        ok = 1'b1;
        return;
      end
    end
  endtask

  task automatic wait_end(output bit ok);
    ok = 1'b0;
    for (int c = 0; c < 30000; c++) begin
      tick();
      if (done || fail) begin
        ok = 1'b1;
        return;
      end
    end
  endtask

  task automatic run_fleet(input int delay, output bit ok);
    ack_delay = delay;
    wq.delete();
    pulse_start();
    wait_end(ok);
  endtask

  // ---------------- scenario table ----------------
  typedef struct {
    string name;
    int    delay;
    int    exp_we;
    bit    exp_done;
    bit    exp_fail;
  } vec_t;

  vec_t       vecs[5];
  logic [3:0] exp_dims[5] = '{4'd5, 4'd4, 4'd3, 4'd3, 4'd2};

  initial begin : watchdog
    #10ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : main
    bit ok;
    int changes;
    int fleets_ok;

    vecs[0] = '{"ack_first_wait", 1, 5,  1'b1, 1'b0};
    vecs[1] = '{"ack_second_wait", 2, 5, 1'b1, 1'b0};
    vecs[2] = '{"ack_on_timeout", 4, 5,  1'b1, 1'b0};
    vecs[3] = '{"ack_too_late",   5, 64, 1'b0, 1'b1};
    vecs[4] = '{"no_ack",         0, 64, 1'b0, 1'b1};

    // Reset values while rst_n is held low.
    repeat (2) tick();
    check("rst_we",   bus.we, 0);
    check("rst_flags", {busy, done, fail}, 3'b000);
    check("rst_dim",  bus.dimension, 5);
    check("rst_newv", bus.new_value, 2);
    check("rst_pos",  {bus.cell_x, bus.cell_y, bus.direction}, 9'd0);

    // Released without start: everything stays put.
    rst_n = 1'b1;
    changes = 0;
    for (int c = 0; c < 10; c++) begin
      tick();
      if ({bus.we, busy, done, fail, bus.dimension, bus.cell_x, bus.cell_y, bus.direction}
          !== {4'b0000, 4'd5, 9'd0}) changes++;
    end
    check("idle_static", changes, 0);

    // Start outside the placing turn is ignored.
    play_status = 2'd1;
    pulse_start();
    repeat (3) tick();
    check("start_wrong_turn_busy", busy, 0);
    check("start_wrong_turn_we", wq.size(), 0);
    play_status = TURN;

    // Table of fleet scenarios.
    for (int i = 0; i < 5; i++) begin
      run_fleet(vecs[i].delay, ok);
      check({vecs[i].name, "_end"}, ok, 1);
      check({vecs[i].name, "_we_count"}, wq.size(), vecs[i].exp_we);
      check({vecs[i].name, "_flags"}, {busy, done, fail}, {1'b0, vecs[i].exp_done, vecs[i].exp_fail});
      for (int k = 0; k < wq.size() && k < vecs[i].exp_we; k++)
        check({vecs[i].name, "_dim"}, wq[k].dim, vecs[i].exp_done ? exp_dims[k] : 4'd5);
      repeat (8) tick();
      check({vecs[i].name, "_sticky"}, {busy, done, fail}, {1'b0, vecs[i].exp_done, vecs[i].exp_fail});
    end

    // Start pulse during GEN of the fourth ship is ignored.
    ack_delay = 1;
    wq.delete();
    pulse_start();
    for (int s = 0; s < 3; s++) begin
      wait_we(ok);
      check("gen_start_we_seen", ok, 1);
    end
    tick();  // WAIT
    tick();  // NEXT
    tick();  // GEN
    start = 1'b1;
    tick();
    start = 1'b0;
    check("gen_start_busy", busy, 1);
    wait_end(ok);
    check("gen_start_end", ok, 1);
    check("gen_start_done", {done, fail}, 2'b10);
    check("gen_start_we_count", wq.size(), 5);
    if (wq.size() == 5) begin
      check("gen_start_dim3", wq[3].dim, 3);
      check("gen_start_dim4", wq[4].dim, 2);
    end
    repeat (8) tick();

    // Abort during WAIT of the second ship, then restart.
    ack_delay = 3;
    wq.delete();
    pulse_start();
    wait_we(ok);
    check("abort_we1", ok, 1);
    wait_we(ok);
    check("abort_we2", ok, 1);
    check("abort_dim2", bus.dimension, 4);
    tick();  // first WAIT cycle
    play_status = 2'd0;
    tick();
    check("abort_flags", {bus.we, busy, done, fail}, 4'b0000);
    check("abort_we_count", wq.size(), 2);
    play_status = TURN;
    repeat (8) tick();
    ack_delay = 1;
    wq.delete();
    pulse_start();
    wait_we(ok);
    check("restart_we", ok, 1);
    check("restart_dim", bus.dimension, 5);
    wait_end(ok);
    check("restart_end", ok, 1);
    check("restart_done", {busy, done, fail}, 3'b010);
    check("restart_we_count", wq.size(), 5);
    repeat (8) tick();

    // Reset asserted during WRITE clears we without a clock edge.
    ack_delay = 1;
    wq.delete();
    pulse_start();
    wait_we(ok);
    check("rst_write_seen", ok, 1);
    rst_n = 1'b0;
    #1;
    check("rst_write_we", bus.we, 0);
    check("rst_write_busy", busy, 0);
    check("rst_write_dim", bus.dimension, 5);
    model_lfsr = SEED;
    tick();
    rst_n = 1'b1;
    tick();
    check("rst_write_no_log", wq.size(), 0);

    // Many fleets back to back: the monitor checks every write.
    fleets_ok = 0;
    for (int f = 0; f < 500; f++) begin
      run_fleet(1, ok);
      if (ok && done && !fail && wq.size() == 5) fleets_ok++;
      tick();
    end
    check("bulk_fleets", fleets_ok, 500);
    check("range_viol", range_viol, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
